w_schedule_streamer: RTL and testbench
======================================

// Module: w_schedule_streamer
// PURPOSE
//  SHA-256 message-schedule reader. Accepts one 512-bit message block, holds a
//  16-word sliding window and streams W[0]..W[W_LENGTH-1], one 32-bit word per
//  valid/ready handshake, to the compression-round datapath.
//  W[0..15] come from the block; W[16..] are expanded in place from the window.
//  Replaces the wide bit-vector W hand-off with a narrow word stream.
// PARAMETERS
//  W_LENGTH  64  words emitted per block; legal range 17..64
// PORTS
//  clock        in   1    clock
//  reset        in   1    synchronous, active-high
//  block_valid  in   1    block_data holds a block to load
//  block_ready  out  1    streamer can accept a block
//  block_data   in   512  message block; W[0]=[511:480] ... W[15]=[31:0]
//  w_valid      out  1    w_word/w_index/w_last valid
//  w_ready      in   1    round datapath takes the word
//  w_word       out  32   W[t]
//  w_index      out  6    t, 0..W_LENGTH-1
//  w_last       out  1    1 when t==W_LENGTH-1
//  busy         out  1    block loaded, stream in progress
// BEHAVIOUR
//  Clock and reset: clock, synchronous active-high reset.
//  Reset (any cycle, mid-stream too): state=IDLE, window, t=0; block_ready=1,
//   w_valid=0, w_word=0, w_index=0, w_last=0, busy=0. Partial block is dropped.
//  FSM IDLE: block_ready=1, w_valid=0. On block_valid&&block_ready: load
//   win[i]=block_data[511-32i -: 32], t=0, go STREAM. First w_valid is the
//   next cycle (1-cycle load latency).
//  FSM STREAM: block_ready=0, busy=1, w_valid=1, w_word=win[0], w_index=t.
//   On w_valid&&w_ready: win[i]<=win[i+1] (i=0..14),
//   win[15]<=s1(win[14])+win[9]+s0(win[1])+win[0] mod 2^32 (=W[t+16]), t<=t+1.
//   Handshake with t==W_LENGTH-1 -> IDLE, w_valid=0 next cycle.
//  s0(x)=ROTR7^ROTR18^SHR3; s1(x)=ROTR17^ROTR19^SHR10; adds truncate to 32b.
//  Words expanded past W_LENGTH-1 are computed but never emitted.
//  Backpressure: w_ready=0 holds w_word/w_index/w_last/window unchanged.
//  No overlap: the next block loads only in IDLE, so there is >=1 bubble cycle
//   between the last word of block N and W[0] of block N+1.
//  block_valid in STREAM is ignored (not consumed); upstream holds it.
//  w_ready is accepted when w_valid=0 and has no effect.
// STRUCTURE
//  Package sha256_pkg: WORD_W=32, BLOCK_W=512, WIN_DEPTH=16, typedef word_t,
//   state enum {IDLE, STREAM}, functions sig0/sig1.
//  Sub-module w_expand_word: combinational s1(a)+b+s0(c)+d from
//   (win[14],win[9],win[1],win[0]) -> 32b. Window, counter and FSM stay here.
// TESTING
//  "abc" block (0x61626380, 14x0, 0x00000018), w_ready=1 -> W0=61626380,
//   W15=00000018, W16=61626380, W17=000F0000, W18=7DA86405, w_last at t=63.
//  All-zero block -> 64 words all 0, indices 0..63, one w_last pulse.
//  "abc" with w_ready toggled pseudo-randomly -> same word sequence as the
//   w_ready=1 run; outputs stable across every stall cycle.
//  Reset at t=20 mid-stream -> next cycle w_valid=0, block_ready=1; a new
//   block then streams from W0 with no data left over from the dropped block.
//  Two blocks back-to-back, block_valid held high -> block_ready low during
//   STREAM, second block loads in IDLE after t=63, its W0 follows one bubble.
//  W_LENGTH=17 -> 17 words emitted, W16 correct, w_last at t=16.

Source files
------------

// File: rtl/w_schedule_streamer_pkg.sv
// Shared SHA-256 schedule types, widths and the small-sigma mixing functions.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int WIN_DEPTH = 16;
    localparam int IDX_W     = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/w_schedule_streamer_if.sv
// Block load port plus W word stream between the streamer and the round datapath.
interface w_schedule_streamer_if;
    import sha256_pkg::*;

    logic                 block_valid;
    logic                 block_ready;
    logic [BLOCK_W-1:0]   block_data;
    logic                 w_valid;
    logic                 w_ready;
    word_t                w_word;
    logic [IDX_W-1:0]     w_index;
    logic                 w_last;
    logic                 busy;

    // master is the streamer itself; slave is the block source / word consumer
    modport master (
        input  block_valid, block_data, w_ready,
        output block_ready, w_valid, w_word, w_index, w_last, busy
    );

    modport slave (
        output block_valid, block_data, w_ready,
        input  block_ready, w_valid, w_word, w_index, w_last, busy
    );

endinterface

// File: rtl/w_schedule_streamer_expand.sv
// Next schedule word from the sliding window: s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
module w_expand_word
    import sha256_pkg::*;
(
    input  word_t win14,
    input  word_t win9,
    input  word_t win1,
    input  word_t win0,
    output word_t w_new
);

    assign w_new = sig1(win14) + win9 + sig0(win1) + win0;

endmodule

// File: rtl/w_schedule_streamer.sv
// Loads one 512-bit block into a 16-word window and streams W[0..W_LENGTH-1]
// over a valid/ready handshake, expanding W[t+16] in place as each word leaves.
module w_schedule_streamer
    import sha256_pkg::*;
#(
    parameter int W_LENGTH = 64     // legal 17..64
) (
    input  logic                   clock,
    input  logic                   reset,
    w_schedule_streamer_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_T = IDX_W'(W_LENGTH - 1);

    state_t            state, state_nx;
    word_t             win [WIN_DEPTH];
    logic [IDX_W-1:0]  t;
    word_t             w_new;
    logic              load, adv, at_last, streaming;

    assign streaming = (state == STREAM);
    assign at_last   = (t == LAST_T);

    w_expand_word u_expand (
        .win14 (win[14]),
        .win9  (win[9]),
        .win1  (win[1]),
        .win0  (win[0]),
        .w_new (w_new)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        adv      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.block_valid) begin
                    load     = 1'b1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (bus.w_ready) begin
                    adv = 1'b1;
                    if (at_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Window and index only move on a load or an accepted word, so a stall
    // leaves every output stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
            t <= '0;
        end else if (load) begin
            for (int i = 0; i < WIN_DEPTH; i++)
                win[i] <= bus.block_data[BLOCK_W-1-WORD_W*i -: WORD_W];
            t <= '0;
        end else if (adv) begin
            for (int i = 0; i < WIN_DEPTH-1; i++) win[i] <= win[i+1];
            win[WIN_DEPTH-1] <= w_new;
            t <= at_last ? '0 : t + 1'b1;
        end
    end

    assign bus.block_ready = (state == IDLE);
    assign bus.w_valid     = streaming;
    assign bus.busy        = streaming;
    assign bus.w_word      = streaming ? win[0] : '0;
    assign bus.w_index     = t;
    assign bus.w_last      = streaming && at_last;

endmodule

// File: tb/tb_w_schedule_streamer.sv
// Scoreboard bench: stimulus queues expected words, monitors pop and compare.
module tb_w_schedule_streamer;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    w_schedule_streamer_if b();
    w_schedule_streamer_if b17();

    w_schedule_streamer #(.W_LENGTH(64)) dut (.clock(clock), .reset(reset), .bus(b));
    w_schedule_streamer #(.W_LENGTH(17)) dut17 (.clock(clock), .reset(reset), .bus(b17));

    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ZERO = 512'h0;

    int n_chk = 0;
    int n_err = 0;
    int n_pop = 0;
    int rdy_mode = 0;
    exp_t q[$];
    exp_t q17[$];
    logic [31:0] sched [64];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    task automatic build(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) sched[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            sched[i] = (rr(sched[i-2], 17) ^ rr(sched[i-2], 19) ^ (sched[i-2] >> 10))
                     + sched[i-7]
                     + (rr(sched[i-15], 7) ^ rr(sched[i-15], 18) ^ (sched[i-15] >> 3))
                     + sched[i-16];
    endtask

    // Known "abc" schedule words pinned by hand on top of the model.
    task automatic build_abc();
        build(ABC);
        sched[0]  = 32'h61626380;
        sched[15] = 32'h00000018;
        sched[16] = 32'h61626380;
        sched[17] = 32'h000F0000;
        sched[18] = 32'h7DA86405;
    endtask

    task automatic push_exp(input int len, input bit to17);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.w = sched[i];
            e.idx = 6'(i);
            e.last = (i == len - 1);
            if (to17) q17.push_back(e);
            else q.push_back(e);
        end
    endtask

    task automatic load64(input logic [511:0] blk);
        bit ok;
        ok = 0;
        b.block_data = blk;
        b.block_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (b.block_ready) ok = 1;
        end
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL load_timeout actual=busy required=ready");
        end
        @(posedge clock); #1;
        b.block_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (q.size() > 0 || q17.size() > 0); i++) @(posedge clock);
        if (q.size() > 0 || q17.size() > 0) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout actual=%0d/%0d left required=0", q.size(), q17.size());
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("idle_after", {61'h0, b.w_valid, b.block_ready, b.busy}, 64'b010);
        @(posedge clock); #1;
    endtask

    // w_ready driver: always-on or pseudo-random stalls
    initial begin
        b.w_ready = 1'b1;
        b17.w_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            b.w_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Main DUT monitor: word order, stall stability, bubble after last.
    initial begin
        exp_t e;
        bit stalled, bubble;
        logic [38:0] held;
        stalled = 0; bubble = 0; held = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stalled = 0; bubble = 0;
            end else begin
                if (bubble) chk("bubble_after_last", {63'h0, b.w_valid}, 64'h0);
                bubble = 0;
                if (stalled) chk("stall_hold", {24'h0, b.w_valid, b.w_word, b.w_index, b.w_last},
                                 {24'h0, 1'b1, held});
                stalled = 0;
                if (b.w_valid) begin
                    chk("ready_busy_in_stream", {62'h0, b.block_ready, b.busy}, 64'b01);
                    if (b.w_ready) begin
                        if (q.size() == 0) begin
                            n_chk++; n_err++;
                            $display("FAIL extra_word actual=t%0d %h required=none", b.w_index, b.w_word);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("word_t%0d", e.idx), {25'h0, b.w_word, b.w_index, b.w_last},
                                {25'h0, e.w, e.idx, e.last});
                        end
                        n_pop++;
                        if (b.w_last) bubble = 1;
                    end else begin
                        stalled = 1;
                        held = {b.w_word, b.w_index, b.w_last};
                    end
                end
            end
        end
    end

    // W_LENGTH=17 instance monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && b17.w_valid && b17.w_ready) begin
                if (q17.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL extra_word17 actual=t%0d %h required=none", b17.w_index, b17.w_word);
                end else begin
                    e = q17.pop_front();
                    chk($sformatf("word17_t%0d", e.idx), {25'h0, b17.w_word, b17.w_index, b17.w_last},
                        {25'h0, e.w, e.idx, e.last});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit hit;
        b.block_valid = 1'b0;  b.block_data = '0;
        b17.block_valid = 1'b0; b17.block_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", {22'h0, b.block_ready, b.w_valid, b.w_word, b.w_index, b.w_last, b.busy},
            {22'h0, 1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0});
        chk("reset_outputs17", {22'h0, b17.block_ready, b17.w_valid, b17.w_word, b17.w_index, b17.w_last, b17.busy},
            {22'h0, 1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0});
        @(posedge clock); #1;
        reset = 1'b0;

        // "abc", no backpressure
        build_abc(); push_exp(64, 0);
        load64(ABC); drain(400);

        // all-zero block
        build(ZERO); push_exp(64, 0);
        load64(ZERO); drain(400);

        // "abc" with random stalls
        rdy_mode = 1;
        build_abc(); push_exp(64, 0);
        load64(ABC); drain(1000);
        rdy_mode = 0;

        // reset at t=20, then a fresh zero block
        build_abc(); push_exp(64, 0);
        base = n_pop;
        load64(ABC);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (n_pop == base + 20) hit = 1;
            else begin @(posedge clock); #1; end
        end
        chk("reached_t20", {63'h0, hit}, 64'h1);
        reset = 1'b1;
        q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_reset_state", {60'h0, b.w_valid, b.block_ready, b.busy, b.w_last}, 64'b0100);
        @(posedge clock); #1;
        build(ZERO); push_exp(64, 0);
        load64(ZERO); drain(400);

        // back-to-back blocks with block_valid held high
        build_abc(); push_exp(64, 0);
        build(ZERO); push_exp(64, 0);
        load64(ABC);
        b.block_valid = 1'b1;
        b.block_data = ZERO;
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clock);
            if (b.block_ready) hit = 1;
        end
        chk("b2b_second_accept", {31'h0, hit, 32'(q.size())}, {31'h0, 1'b1, 32'd64});
        @(posedge clock); #1;
        b.block_valid = 1'b0;
        drain(400);

        // W_LENGTH=17 instance
        build_abc(); push_exp(17, 1);
        b17.block_data = ABC;
        b17.block_valid = 1'b1;
        @(posedge clock); #1;
        b17.block_valid = 1'b0;
        drain(100);
        chk("idle17_after", {61'h0, b17.w_valid, b17.block_ready, b17.busy}, 64'b010);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
